// File: rtl/posit_extract_arbiter_pkg.sv
// Shared definitions for the posit decode arbiter slice.
//   NBITS / ES    : posit format (32-bit, es=2)
//   NREQ_DEFAULT  : default requester count for the arbiter top
//   value_t       : decoded posit (sign, scale, left-aligned fraction, zero, inf)
package posit_extract_arbiter_pkg;

    localparam int NBITS        = 32;
    localparam int ES           = 2;
    localparam int NREQ_DEFAULT = 4;

    // Fraction is left-aligned, hidden bit not included. The shortest regime
    // is 2 bits, so the bottom two fraction bits are always zero.
    localparam int FRAC_W  = NBITS - 1 - ES;
    localparam int SCALE_W = $clog2(NBITS) + ES + 2;

    typedef struct packed {
        logic                      sgn;
        logic signed [SCALE_W-1:0] scale;
        logic [FRAC_W-1:0]         fraction;
        logic                      zero;
        logic                      inf;
    } value_t;

endpackage

// File: rtl/posit_extract_arbiter_if.sv
// Bundle of requester-side and result-side signals of posit_extract_arbiter.
//   in_valid/in_data/in_ready : NREQ requesters, posit i at [i*NBITS +: NBITS]
//   out_valid/out_ready       : result handshake
//   out_tag/out_value/out_abs : requester index, decoded posit, magnitude bits
//   busy                      : any pipeline stage occupied
// slave  : the arbiter side.  master : the requester/consumer side.
interface posit_extract_arbiter_if
    import posit_extract_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int TAGW = $clog2(NREQ)
);

    logic [NREQ-1:0]       in_valid;
    logic [NREQ*NBITS-1:0] in_data;
    logic [NREQ-1:0]       in_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [TAGW-1:0]       out_tag;
    value_t                out_value;
    logic [NBITS-2:0]      out_abs;
    logic                  busy;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_tag, out_value, out_abs, busy
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_tag, out_value, out_abs, busy
    );

endinterface

// File: rtl/posit_extract_arbiter_extract.sv
// Combinational posit decoder.
//   posit : NBITS-bit posit
//   value : sign, scale (regime*2^ES + exponent), left-aligned fraction, zero, inf
//   mag   : low NBITS-1 bits of the two's-complement magnitude
module posit_extract
    import posit_extract_arbiter_pkg::*;
(
    input  logic [NBITS-1:0] posit,
    output value_t           value,
    output logic [NBITS-2:0] mag
);

    localparam int RUN_W = $clog2(NBITS) + 1;
    localparam logic signed [SCALE_W-1:0] ONE_S = SCALE_W'(1);

    logic [NBITS-2:0]          body;
    logic [NBITS-2:0]          run_x;
    logic [NBITS-2:0]          rem;
    logic [RUN_W-1:0]          run;
    logic                      found;
    logic signed [SCALE_W-1:0] run_s;
    logic signed [SCALE_W-1:0] k;
    logic [ES-1:0]             expo;
    logic                      is_zero;
    logic                      is_inf;

    always_comb begin
        body = posit[NBITS-1] ? (~posit[NBITS-2:0] + (NBITS-1)'(1)) : posit[NBITS-2:0];

        // Regime run length = leading zeros of body XOR its own first bit.
        run_x = body ^ {(NBITS-1){body[NBITS-2]}};
        run   = RUN_W'(NBITS-1);
        found = 1'b0;
        for (int i = NBITS-2; i >= 0; i--) begin
            if (!found && run_x[i]) begin
                found = 1'b1;
                run   = RUN_W'(NBITS-2-i);
            end
        end

        // Drop the regime run plus its terminating bit; a full-length run
        // shifts everything out.
        rem   = body << (run + RUN_W'(1));
        run_s = $signed(SCALE_W'(run));
        k     = body[NBITS-2] ? (run_s - ONE_S) : -run_s;
        expo  = rem[NBITS-2 -: ES];

        is_zero = (posit == '0);
        is_inf  = (posit == {1'b1, {(NBITS-1){1'b0}}});

        value.sgn  = posit[NBITS-1];
        value.zero = is_zero;
        value.inf  = is_inf;
        if (is_zero || is_inf) begin
            value.scale    = '0;
            value.fraction = '0;
        end else begin
            value.scale    = (k <<< ES) + $signed(SCALE_W'(expo));
            value.fraction = rem[FRAC_W-1:0];
        end
        mag = body;
    end

endmodule

// File: rtl/posit_extract_arbiter_rr.sv
// Generic round-robin arbiter.
//   req   : request vector
//   ptr   : index of the last winner; search starts at ptr+1 (mod N)
//   en    : when low, no grant is issued
//   grant : one-hot (or zero) grant
//   idx   : encoded index of the winner (valid when any=1)
//   any   : a grant is issued
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        // First pass covers indices above ptr, second pass wraps to 0..ptr,
        // giving the cyclic order ptr+1, ..., N-1, 0, ..., ptr.
        for (int i = 0; i < N; i++) begin
            if (!any && req[i] && (i > int'(ptr))) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                idx      = IW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!any && req[i] && (i <= int'(ptr))) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                idx      = IW'(i);
            end
        end
        if (!en) begin
            grant = '0;
            any   = 1'b0;
        end
    end

endmodule

// File: rtl/posit_extract_arbiter.sv
// Shares one posit_extract decoder between NREQ requesters. A round-robin
// arbiter picks one posit per cycle into the issue register (S1); the decoder
// sits between S1 and the output register (S2). One result per cycle, tagged
// with the requester index.
//   clk, reset : clock (rising edge), asynchronous active-high reset
//   bus        : posit_extract_arbiter_if.slave (requesters, result, busy)
module posit_extract_arbiter
    import posit_extract_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int TAGW = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    posit_extract_arbiter_if.slave   bus
);

    logic             adv1;
    logic             adv2;
    logic [NREQ-1:0]  grant;
    logic [TAGW-1:0]  win_idx;
    logic             win_any;
    logic [NBITS-1:0] win_posit;
    logic [TAGW-1:0]  ptr;

    logic [NBITS-1:0] posit_p1;
    logic [TAGW-1:0]  tag_p1;
    logic             vld_p1;

    value_t           dec_value;
    logic [NBITS-2:0] dec_mag;

    value_t           value_p2;
    logic [NBITS-2:0] mag_p2;
    logic [TAGW-1:0]  tag_p2;
    logic             vld_p2;

    // Only in_ready sees out_ready combinationally; the outputs are registers.
    assign adv2 = ~vld_p2 | bus.out_ready;
    assign adv1 = ~vld_p1 | adv2;

    rr_arbiter #(
        .N  (NREQ),
        .IW (TAGW)
    ) u_arb (
        .req   (bus.in_valid),
        .ptr   (ptr),
        .en    (adv1),
        .grant (grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    always_comb begin
        win_posit = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                win_posit = bus.in_data[i*NBITS +: NBITS];
            end
        end
    end

    assign bus.in_ready = grant;

    posit_extract u_ext (
        .posit (posit_p1),
        .value (dec_value),
        .mag   (dec_mag)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1   <= 1'b0;
            posit_p1 <= '0;
            tag_p1   <= '0;
            vld_p2   <= 1'b0;
            value_p2 <= '0;
            mag_p2   <= '0;
            tag_p2   <= '0;
            // ptr holds the last winner: NREQ-1 makes requester 0 first.
            ptr      <= TAGW'(NREQ-1);
        end else begin
            // S1 -> decode -> S2
            if (adv2) begin
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    value_p2 <= dec_value;
                    mag_p2   <= dec_mag;
                    tag_p2   <= tag_p1;
                end
            end
            // arbiter -> S1; win_any is already gated by adv1, so it marks a handshake
            if (adv1) begin
                vld_p1 <= win_any;
                if (win_any) begin
                    posit_p1 <= win_posit;
                    tag_p1   <= win_idx;
                    ptr      <= win_idx;
                end
            end
        end
    end

    assign bus.out_valid = vld_p2;
    assign bus.out_tag   = tag_p2;
    assign bus.out_value = value_p2;
    assign bus.out_abs   = mag_p2;
    assign bus.busy      = vld_p1 | vld_p2;

endmodule
